// File: rtl/multi_cycle_ctrl_if.sv
// Signal bundle between the multi-cycle MIPS main control FSM (master) and its datapath (slave).
interface multi_cycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       instr_op_i;
    logic             PCWrite_o;
    logic             PCWriteCond_o;
    logic             IorD_o;
    logic             MemRead_o;
    logic             MemWrite_o;
    logic             IRWrite_o;
    logic             MemtoReg_o;
    logic             RegDst_o;
    logic             RegWrite_o;
    logic             ALUSrcA_o;
    logic [1:0]       ALUSrcB_o;
    logic [1:0]       PCSource_o;
    logic [2:0]       ALUOp_o;
    logic [3:0]       state_o;
    logic             instr_done_o;
    logic [CNT_W-1:0] instr_cnt_o;
    logic             trap_o;

    modport master (
        input  instr_op_i,
        output PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, state_o, instr_done_o, instr_cnt_o, trap_o
    );

    modport slave (
        output instr_op_i,
        input  PCWrite_o, PCWriteCond_o, IorD_o, MemRead_o, MemWrite_o, IRWrite_o,
               MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o,
               ALUOp_o, state_o, instr_done_o, instr_cnt_o, trap_o
    );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle MIPS datapath, with a retired-instruction counter.
// Optional MC_CTRL_ILLEGAL_TRAP_EN: undefined opcodes lock the FSM in TRAP instead of acting as a NOP.
//
// state  | meaning
// 0  IDLE   | after reset, all strobes low
// 1  FETCH  | read instruction, PC += 4
// 2  DECODE | latch opcode, precompute branch target
// 3  MEMADR | compute lw/sw address
// 4  MEMRD  | memory read (lw)
// 5  MEMWB  | MDR to regfile (lw done)
// 6  MEMWR  | memory write (sw done)
// 7  EXEC   | R-type ALU operation
// 8  RWB    | ALUOut to rd (R done)
// 9  BRANCH | beq compare and conditional PC load (done)
// 10 JUMP   | PC load from jump target (done)
// 11 IEXEC  | addi/slti ALU operation
// 12 IWB    | ALUOut to rt (addi/slti done)
// 13 TRAP   | illegal opcode, held until reset (trap build only)
module multi_cycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    multi_cycle_ctrl_if.master  bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_RWB    = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_IEXEC  = 4'd11,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        S_TRAP   = 4'd13,
`endif
        S_IWB    = 4'd12
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_op;
    logic [CNT_W-1:0] r_cnt;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mem_to_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_pc_source;
    logic [2:0] w_alu_op;
    logic       w_done;
    logic       w_trap;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op <= bus.instr_op_i;
            end
            if (w_done) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_next          = S_IDLE;
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mem_to_reg    = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_pc_source     = 2'b00;
        w_alu_op        = 3'b000;
        w_done          = 1'b0;
        w_trap          = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                w_alu_src_b = 2'b01;
                w_alu_op    = 3'b010;
                w_next      = S_DECODE;
            end
            S_DECODE: begin
                w_alu_src_b = 2'b11;
                w_alu_op    = 3'b010;
                case (bus.instr_op_i)
                    OP_LW, OP_SW:     w_next = S_MEMADR;
                    OP_R:             w_next = S_EXEC;
                    OP_BEQ:           w_next = S_BRANCH;
                    OP_J:             w_next = S_JUMP;
                    OP_ADDI, OP_SLTI: w_next = S_IEXEC;
                    default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                        w_next = S_TRAP;
`else
                        // Undefined opcode retires as a two-cycle NOP, so done depends on the live opcode here.
                        w_next = S_FETCH;
                        w_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = 3'b010;
                w_next      = (r_op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
                w_next     = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_done       = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWR: begin
                w_mem_write = 1'b1;
                w_iord      = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 3'b100;
                w_next      = S_RWB;
            end
            S_RWB: begin
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 3'b011;
                w_pc_write_cond = 1'b1;
                w_pc_source     = 2'b01;
                w_done          = 1'b1;
                w_next          = S_FETCH;
            end
            S_JUMP: begin
                w_pc_write  = 1'b1;
                w_pc_source = 2'b10;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
            S_IEXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
                w_alu_op    = (r_op == OP_SLTI) ? 3'b001 : 3'b010;
                w_next      = S_IWB;
            end
            S_IWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
                w_next      = S_FETCH;
            end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: begin
                w_trap = 1'b1;
                w_next = S_TRAP;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.PCWrite_o     = w_pc_write;
    assign bus.PCWriteCond_o = w_pc_write_cond;
    assign bus.IorD_o        = w_iord;
    assign bus.MemRead_o     = w_mem_read;
    assign bus.MemWrite_o    = w_mem_write;
    assign bus.IRWrite_o     = w_ir_write;
    assign bus.MemtoReg_o    = w_mem_to_reg;
    assign bus.RegDst_o      = w_reg_dst;
    assign bus.RegWrite_o    = w_reg_write;
    assign bus.ALUSrcA_o     = w_alu_src_a;
    assign bus.ALUSrcB_o     = w_alu_src_b;
    assign bus.PCSource_o    = w_pc_source;
    assign bus.ALUOp_o       = w_alu_op;
    assign bus.state_o       = r_state;
    assign bus.instr_done_o  = w_done;
    assign bus.instr_cnt_o   = r_cnt;
    assign bus.trap_o        = w_trap;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl: per-instruction state-path model, every-cycle compare, literal pins.
module tb_multi_cycle_ctrl;
    localparam int CW = 4;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
        logic [1:0] srcb, pcsrc;
        logic [2:0] aluop;
        logic       done, trap;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if #(.CNT_W(CW)) bus ();
    multi_cycle_ctrl #(.CNT_W(CW)) dut (.clk_i(clk), .rst_i(rst_n), .bus(bus.master));

    int n_chk = 0;
    int n_fail = 0;
    int done_seen = 0;
    logic          chk_en = 1'b0;
    int            exp_state = 0;
    logic [5:0]    exp_op = '0;
    logic [CW-1:0] exp_cnt = '0;
    logic          inc_pending = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_SLTI, OP_J};
    endfunction

    // Expected state path of one instruction, FETCH first.
    function automatic int path_len(input logic [5:0] op);
        case (op)
            OP_LW:                   return 5;
            OP_SW, OP_R:             return 4;
            OP_ADDI, OP_SLTI:        return 4;
            OP_BEQ, OP_J:            return 3;
            default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                return 3;
`else
                return 2;
`endif
            end
        endcase
    endfunction

    function automatic int path_state(input logic [5:0] op, input int idx);
        int third;
        if (idx == 0) return 1;
        if (idx == 1) return 2;
        case (op)
            OP_LW:            third = 3;
            OP_SW:            third = 3;
            OP_R:             third = 7;
            OP_BEQ:           third = 9;
            OP_J:             third = 10;
            OP_ADDI, OP_SLTI: third = 11;
            default:          third = 13;
        endcase
        if (idx == 2) return third;
        case (op)
            OP_LW:            return (idx == 3) ? 4 : 5;
            OP_SW:            return 6;
            OP_R:             return 8;
            default:          return 12;
        endcase
    endfunction

    function automatic vec_t exp_vec(input int s, input logic [5:0] op);
        vec_t v;
        v = '0;
        case (s)
            1:  begin v.mrd = 1; v.irw = 1; v.pcw = 1; v.srcb = 2'b01; v.aluop = 3'b010; end
            2:  begin
                    v.srcb = 2'b11; v.aluop = 3'b010;
`ifndef MC_CTRL_ILLEGAL_TRAP_EN
                    v.done = !is_legal(op);
`endif
                end
            3:  begin v.srca = 1; v.srcb = 2'b10; v.aluop = 3'b010; end
            4:  begin v.mrd = 1; v.iord = 1; end
            5:  begin v.rw = 1; v.m2r = 1; v.done = 1; end
            6:  begin v.mwr = 1; v.iord = 1; v.done = 1; end
            7:  begin v.srca = 1; v.aluop = 3'b100; end
            8:  begin v.rw = 1; v.rdst = 1; v.done = 1; end
            9:  begin v.srca = 1; v.aluop = 3'b011; v.pcwc = 1; v.pcsrc = 2'b01; v.done = 1; end
            10: begin v.pcw = 1; v.pcsrc = 2'b10; v.done = 1; end
            11: begin v.srca = 1; v.srcb = 2'b10; v.aluop = (op == OP_SLTI) ? 3'b001 : 3'b010; end
            12: begin v.rw = 1; v.done = 1; end
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            13: v.trap = 1;
`endif
            default: v = '0;
        endcase
        return v;
    endfunction

    vec_t act_vec;
    assign act_vec = '{pcw: bus.PCWrite_o, pcwc: bus.PCWriteCond_o, iord: bus.IorD_o,
                       mrd: bus.MemRead_o, mwr: bus.MemWrite_o, irw: bus.IRWrite_o,
                       m2r: bus.MemtoReg_o, rdst: bus.RegDst_o, rw: bus.RegWrite_o,
                       srca: bus.ALUSrcA_o, srcb: bus.ALUSrcB_o, pcsrc: bus.PCSource_o,
                       aluop: bus.ALUOp_o, done: bus.instr_done_o, trap: bus.trap_o};

    always @(negedge clk) begin
        if (bus.instr_done_o) done_seen++;
        if (chk_en) begin
            check("state_o", 32'(bus.state_o), 32'(exp_state));
            check("strobes", 32'(act_vec), 32'(exp_vec(exp_state, exp_op)));
            check("instr_cnt_o", 32'(bus.instr_cnt_o), 32'(exp_cnt));
        end
    end

    task automatic step(input int s);
        @(posedge clk);
        #1;
        if (inc_pending) begin
            exp_cnt = exp_cnt + 1'b1;
            inc_pending = 1'b0;
        end
        exp_state = s;
    endtask

    task automatic run_instr(input logic [5:0] op);
        int n;
        n = path_len(op);
        bus.instr_op_i = op;
        exp_op = op;
        for (int i = 0; i < n; i++) begin
            step(path_state(op, i));
            if (i == 2) bus.instr_op_i = op ^ 6'b111111;
        end
        if (exp_state != 13) inc_pending = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_state = 0;
        exp_cnt = '0;
        inc_pending = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    int d0;

    initial begin
        bus.instr_op_i = OP_LW;
        exp_op = OP_LW;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(OP_LW);
        step(1);
        check("lw_count", 32'(bus.instr_cnt_o), 32'd1);

        do_reset();
        run_instr(OP_BEQ);
        run_instr(OP_R);
        run_instr(OP_SLTI);
        step(1);
        check("seq_count", 32'(bus.instr_cnt_o), 32'd3);

        do_reset();
        run_instr(OP_SW);
        run_instr(OP_ADDI);
        run_instr(OP_LW);
        run_instr(OP_SW);
        step(1);
        check("mix_count", 32'(bus.instr_cnt_o), 32'd4);

        do_reset();
        run_instr(OP_BAD);
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        repeat (10) step(13);
        check("trap_held", 32'(bus.trap_o), 32'd1);
        check("trap_state", 32'(bus.state_o), 32'd13);
        check("trap_count", 32'(bus.instr_cnt_o), 32'd0);
        do_reset();
        #1;
        check("trap_cleared", 32'(bus.trap_o), 32'd0);
`else
        step(1);
        check("nop_count", 32'(bus.instr_cnt_o), 32'd1);
        check("nop_refetch", 32'(bus.state_o), 32'd1);
        check("no_trap", 32'(bus.trap_o), 32'd0);
        do_reset();
`endif

        // Reset in the middle of MEMRD of a load.
        run_instr(OP_J);
        bus.instr_op_i = OP_LW;
        exp_op = OP_LW;
        for (int i = 0; i < 4; i++) step(path_state(OP_LW, i));
        inc_pending = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        exp_state = 0;
        exp_cnt = '0;
        inc_pending = 1'b0;
        #1;
        check("abort_state", 32'(bus.state_o), 32'd0);
        check("abort_strobes", 32'(act_vec), 32'd0);
        check("abort_count", 32'(bus.instr_cnt_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_instr(OP_LW);

        do_reset();
        d0 = done_seen;
        for (int k = 0; k < 17; k++) run_instr(OP_J);
        step(1);
        check("wrap_count", 32'(bus.instr_cnt_o), 32'd1);
        check("j_done_pulses", 32'(done_seen - d0), 32'd17);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
